// File: rtl/mm2s_packet_router.sv
// Steers one MM2S AXI stream to per-accelerator FIFOs by TDEST, latching the route per packet.
// Packets for disabled/out-of-range channels and tails beyond MAX_BEATS are drained and counted.
module mm2s_packet_router #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int FIFO_DATA_WIDTH = 32,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_DEST_WIDTH = 4,
   parameter int NUM_CHANNELS    = 2,
   parameter int MAX_BEATS       = 1024,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                                    clk_in,
   input  logic                                    rst_n_in,
   input  logic [AXIS_DATA_WIDTH-1:0]              SRC_AXIS_tdata_in,
   input  logic [AXIS_DEST_WIDTH-1:0]              SRC_AXIS_tdest_in,
   input  logic [AXIS_KEEP_WIDTH-1:0]              SRC_AXIS_tkeep_in,
   input  logic                                    SRC_AXIS_tlast_in,
   input  logic                                    SRC_AXIS_tuser_in,
   input  logic                                    SRC_AXIS_tvalid_in,
   output logic                                    SRC_AXIS_tready_out,
   input  logic [NUM_CHANNELS-1:0]                 channel_en_in,
   output logic [NUM_CHANNELS*FIFO_DATA_WIDTH-1:0] fifo_data_out,
   output logic [NUM_CHANNELS-1:0]                 fifo_w_stb_out,
   output logic [NUM_CHANNELS-1:0]                 fifo_last_out,
   input  logic [NUM_CHANNELS-1:0]                 fifo_not_full_in,
   output logic [CNT_WIDTH-1:0]                    drop_count_out,
   output logic [CNT_WIDTH-1:0]                    trunc_count_out,
   output logic                                    busy_out
);

   localparam int CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int BC_W      = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
   localparam int DEST_SPAN = 2 ** AXIS_DEST_WIDTH;
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
   logic [BC_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic                 drop_flag_q, drop_flag_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

   logic [DEST_SPAN-1:0] en_ext;
   logic                 dest_ok;
   logic                 at_limit;
   logic                 tready;
   logic                 accept;

   // tkeep/tuser are carried on the bus but never interpreted.
   logic unused_inputs;
   assign unused_inputs = ^{SRC_AXIS_tkeep_in, SRC_AXIS_tuser_in};

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         cur_ch_q    <= '0;
         beat_cnt_q  <= '0;
         drop_flag_q <= 1'b0;
         drop_cnt_q  <= '0;
         trunc_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         beat_cnt_q  <= beat_cnt_d;
         drop_flag_q <= drop_flag_d;
         drop_cnt_q  <= drop_cnt_d;
         trunc_cnt_q <= trunc_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cur_ch_d       = cur_ch_q;
      beat_cnt_d     = beat_cnt_q;
      drop_flag_d    = drop_flag_q;
      drop_cnt_d     = drop_cnt_q;
      trunc_cnt_d    = trunc_cnt_q;
      tready         = 1'b0;
      accept         = 1'b0;
      fifo_w_stb_out = '0;
      fifo_last_out  = '0;

      // Zero-extended enable map: out-of-range destinations read back as disabled.
      en_ext                   = '0;
      en_ext[NUM_CHANNELS-1:0] = channel_en_in;
      dest_ok                  = en_ext[SRC_AXIS_tdest_in];
      at_limit                 = (beat_cnt_q == LAST_BEAT);

      case (state_q)
         IDLE: begin
            if (SRC_AXIS_tvalid_in) begin
               cur_ch_d   = SRC_AXIS_tdest_in[CH_W-1:0];
               beat_cnt_d = '0;
               if (dest_ok) begin
                  state_d     = ROUTE;
                  drop_flag_d = 1'b0;
               end else begin
                  state_d     = DROP;
                  drop_flag_d = 1'b1;
               end
            end
         end
         ROUTE: begin
            tready = fifo_not_full_in[cur_ch_q];
            accept = SRC_AXIS_tvalid_in & tready;
            if (accept) begin
               fifo_w_stb_out[cur_ch_q] = 1'b1;
               fifo_last_out[cur_ch_q]  = SRC_AXIS_tlast_in | at_limit;
               if (SRC_AXIS_tlast_in) begin
                  state_d = IDLE;
               end else if (at_limit) begin
                  // Overlength: the forwarded beat closed the FIFO packet, drain the rest.
                  state_d     = DROP;
                  drop_flag_d = 1'b0;
                  trunc_cnt_d = sat_inc(trunc_cnt_q);
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         DROP: begin
            tready = 1'b1;
            accept = SRC_AXIS_tvalid_in;
            if (accept && SRC_AXIS_tlast_in) begin
               state_d = IDLE;
               if (drop_flag_q) drop_cnt_d = sat_inc(drop_cnt_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign SRC_AXIS_tready_out = tready;
   assign fifo_data_out       = {NUM_CHANNELS{SRC_AXIS_tdata_in}};
   assign drop_count_out      = drop_cnt_q;
   assign trunc_count_out     = trunc_cnt_q;
   assign busy_out            = (state_q != IDLE);

endmodule

// File: tb/tb_mm2s_packet_router.sv
// Bench for mm2s_packet_router: directed cycle table, reset-abort sequence and
// randomized packets scored against a packet-level expectation queue.
module tb_mm2s_packet_router;

   localparam int DW = 32;
   localparam int NC = 2;
   localparam int MB = 4;
   localparam int CW = 3;
   localparam int DESTW = 4;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic [DW-1:0]     tdata;
   logic [DESTW-1:0]  tdest;
   logic [DW/8-1:0]   tkeep;
   logic              tlast;
   logic              tuser;
   logic              tvalid;
   logic              tready;
   logic [NC-1:0]     ch_en;
   logic [NC*DW-1:0]  fifo_data;
   logic [NC-1:0]     fifo_stb;
   logic [NC-1:0]     fifo_last;
   logic [NC-1:0]     fifo_nf;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     trunc_cnt;
   logic              busy;

   always #5 clk_in = ~clk_in;

   mm2s_packet_router #(
      .AXIS_DATA_WIDTH(DW), .FIFO_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(DW/8),
      .AXIS_DEST_WIDTH(DESTW), .NUM_CHANNELS(NC), .MAX_BEATS(MB), .CNT_WIDTH(CW)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .SRC_AXIS_tdata_in(tdata), .SRC_AXIS_tdest_in(tdest), .SRC_AXIS_tkeep_in(tkeep),
      .SRC_AXIS_tlast_in(tlast), .SRC_AXIS_tuser_in(tuser), .SRC_AXIS_tvalid_in(tvalid),
      .SRC_AXIS_tready_out(tready), .channel_en_in(ch_en),
      .fifo_data_out(fifo_data), .fifo_w_stb_out(fifo_stb), .fifo_last_out(fifo_last),
      .fifo_not_full_in(fifo_nf), .drop_count_out(drop_cnt), .trunc_count_out(trunc_cnt),
      .busy_out(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic           v;
      logic [3:0]     dest;
      logic           last;
      logic [31:0]    data;
      logic [1:0]     en;
      logic [1:0]     nf;
      logic           rdy;
      logic [1:0]     stb;
      logic [1:0]     lst;
      logic           busy;
      logic [2:0]     drop;
      logic [2:0]     trunc;
   } vec_t;

   typedef struct {
      int          ch;
      logic [31:0] d;
      logic        l;
   } wr_t;

   vec_t tbl[33];
   wr_t  expq[$];

   function automatic vec_t mk(logic v, logic [3:0] dest, logic last, logic [31:0] data,
                               logic [1:0] en, logic [1:0] nf, logic rdy, logic [1:0] stb,
                               logic [1:0] lst, logic bsy, logic [2:0] drp, logic [2:0] trc);
      vec_t r;
      r.v = v; r.dest = dest; r.last = last; r.data = data; r.en = en; r.nf = nf;
      r.rdy = rdy; r.stb = stb; r.lst = lst; r.busy = bsy; r.drop = drp; r.trunc = trc;
      return r;
   endfunction

   task automatic drive(logic v, logic [3:0] dest, logic last, logic [31:0] data,
                        logic [1:0] en, logic [1:0] nf);
      tvalid = v; tdest = dest; tlast = last; tdata = data; ch_en = en; fifo_nf = nf;
      tkeep = 4'($urandom); tuser = 1'($urandom);
   endtask

   task automatic check(string name, logic [95:0] act, logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] pack_out();
      return {20'd0, tready, fifo_stb, fifo_last, busy, drop_cnt, trunc_cnt, fifo_data};
   endfunction

   function automatic logic [95:0] pack_exp(logic rdy, logic [1:0] stb, logic [1:0] lst,
                                            logic bsy, logic [2:0] drp, logic [2:0] trc,
                                            logic [31:0] d);
      return {20'd0, rdy, stb, lst, bsy, drp, trc, d, d};
   endfunction

   // Scores any strobe seen this cycle against the head of the expected write queue.
   task automatic mon();
      wr_t w;
      int  ch;
      if (fifo_stb != '0) begin
         n_tests++;
         if (!$onehot(fifo_stb) || !(tvalid && tready) || expq.size() == 0) begin
            n_fail++;
            $display("FAIL rand_strobe: stb=%b valid=%b ready=%b pending=%0d",
                     fifo_stb, tvalid, tready, expq.size());
         end else begin
            w  = expq.pop_front();
            ch = fifo_stb[1] ? 1 : 0;
            if (ch != w.ch || fifo_data[ch*DW +: DW] !== w.d || fifo_last[ch] !== w.l ||
                fifo_last[1-ch] !== 1'b0 || fifo_nf[ch] !== 1'b1) begin
               n_fail++;
               $display("FAIL rand_write: got ch%0d d=%h last=%b nf=%b expected ch%0d d=%h last=%b",
                        ch, fifo_data[ch*DW +: DW], fifo_last, fifo_nf, w.ch, w.d, w.l);
            end
         end
      end
   endtask

   initial begin
      int exp_drop, exp_trunc, len, dest, budget;
      logic [1:0] en;
      logic       ok, done, abort, hdr;
      logic [31:0] beats[7];
      wr_t w;

      // Reset state
      rst_n_in = 1'b0;
      drive(1'b1, 4'd1, 1'b0, 32'h1234_5678, 2'b11, 2'b11);
      #2;
      check("reset_state", pack_out(), pack_exp(1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0, 32'h1234_5678));
      @(negedge clk_in);
      check("reset_held", pack_out(), pack_exp(1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 3'd0, 32'h1234_5678));
      drive(1'b0, 4'd0, 1'b0, 32'h0, 2'b11, 2'b11);
      rst_n_in = 1'b1;

      // single-beat, invalid/disabled drops, backpressure, tlast on beat MAX, truncation, back-to-back
      tbl[0]  = mk(1, 1, 1, 32'hA5A5_0001, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0);
      tbl[1]  = mk(1, 1, 1, 32'hA5A5_0001, 2'b11, 2'b11, 1, 2'b10, 2'b10, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 32'h0000_0000, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0);
      tbl[3]  = mk(1, 5, 0, 32'hD000_0000, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0);
      tbl[4]  = mk(1, 5, 0, 32'hD000_0001, 2'b11, 2'b11, 1, 2'b00, 2'b00, 1, 0, 0);
      tbl[5]  = mk(1, 5, 0, 32'hD000_0002, 2'b11, 2'b11, 1, 2'b00, 2'b00, 1, 0, 0);
      tbl[6]  = mk(1, 5, 1, 32'hD000_0003, 2'b11, 2'b11, 1, 2'b00, 2'b00, 1, 0, 0);
      tbl[7]  = mk(1, 0, 0, 32'hE000_0000, 2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 1, 0);
      tbl[8]  = mk(1, 0, 0, 32'hE000_0000, 2'b10, 2'b11, 1, 2'b00, 2'b00, 1, 1, 0);
      tbl[9]  = mk(1, 0, 1, 32'hE000_0001, 2'b10, 2'b11, 1, 2'b00, 2'b00, 1, 1, 0);
      tbl[10] = mk(0, 0, 0, 32'h0000_0000, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 2, 0);
      tbl[11] = mk(1, 0, 0, 32'hB000_0001, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 2, 0);
      tbl[12] = mk(1, 0, 0, 32'hB000_0001, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 2, 0);
      tbl[13] = mk(1, 0, 0, 32'hB000_0002, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 2, 0);
      tbl[14] = mk(1, 0, 0, 32'hB000_0003, 2'b11, 2'b10, 0, 2'b00, 2'b00, 1, 2, 0);
      tbl[15] = mk(1, 0, 0, 32'hB000_0003, 2'b11, 2'b10, 0, 2'b00, 2'b00, 1, 2, 0);
      tbl[16] = mk(1, 0, 0, 32'hB000_0003, 2'b11, 2'b10, 0, 2'b00, 2'b00, 1, 2, 0);
      tbl[17] = mk(1, 0, 0, 32'hB000_0003, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 2, 0);
      tbl[18] = mk(1, 0, 1, 32'hB000_0004, 2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 2, 0);
      tbl[19] = mk(1, 1, 0, 32'hC000_0001, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 2, 0);
      tbl[20] = mk(1, 1, 0, 32'hC000_0001, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 2, 0);
      tbl[21] = mk(1, 1, 0, 32'hC000_0002, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 2, 0);
      tbl[22] = mk(1, 1, 0, 32'hC000_0003, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 2, 0);
      tbl[23] = mk(1, 1, 0, 32'hC000_0004, 2'b11, 2'b11, 1, 2'b10, 2'b10, 1, 2, 0);
      tbl[24] = mk(1, 1, 0, 32'hC000_0005, 2'b11, 2'b11, 1, 2'b00, 2'b00, 1, 2, 1);
      tbl[25] = mk(1, 1, 1, 32'hC000_0006, 2'b11, 2'b11, 1, 2'b00, 2'b00, 1, 2, 1);
      tbl[26] = mk(1, 0, 0, 32'hF000_0001, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 2, 1);
      tbl[27] = mk(1, 0, 0, 32'hF000_0001, 2'b11, 2'b11, 1, 2'b01, 2'b00, 1, 2, 1);
      tbl[28] = mk(1, 0, 1, 32'hF000_0002, 2'b11, 2'b11, 1, 2'b01, 2'b01, 1, 2, 1);
      tbl[29] = mk(1, 1, 0, 32'h6000_0001, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 2, 1);
      tbl[30] = mk(1, 1, 0, 32'h6000_0001, 2'b11, 2'b11, 1, 2'b10, 2'b00, 1, 2, 1);
      tbl[31] = mk(1, 1, 1, 32'h6000_0002, 2'b11, 2'b11, 1, 2'b10, 2'b10, 1, 2, 1);
      tbl[32] = mk(0, 0, 0, 32'h0000_0000, 2'b11, 2'b11, 0, 2'b00, 2'b00, 0, 2, 1);

      for (int i = 0; i < 33; i++) begin
         @(negedge clk_in);
         drive(tbl[i].v, tbl[i].dest, tbl[i].last, tbl[i].data, tbl[i].en, tbl[i].nf);
         #2;
         check($sformatf("table_row%0d", i), pack_out(),
               pack_exp(tbl[i].rdy, tbl[i].stb, tbl[i].lst, tbl[i].busy,
                        tbl[i].drop, tbl[i].trunc, tbl[i].data));
      end

      // Reset during beat 3 of a 5-beat packet, then a fresh header to channel 1
      @(negedge clk_in); drive(1, 0, 0, 32'h5100_0001, 2'b11, 2'b11); #2;
      check("rst_hdr", pack_out(), pack_exp(0, 2'b00, 2'b00, 0, 2, 1, 32'h5100_0001));
      @(negedge clk_in); drive(1, 0, 0, 32'h5100_0001, 2'b11, 2'b11); #2;
      check("rst_beat1", pack_out(), pack_exp(1, 2'b01, 2'b00, 1, 2, 1, 32'h5100_0001));
      @(negedge clk_in); drive(1, 0, 0, 32'h5100_0002, 2'b11, 2'b11); #2;
      check("rst_beat2", pack_out(), pack_exp(1, 2'b01, 2'b00, 1, 2, 1, 32'h5100_0002));
      @(negedge clk_in); drive(1, 0, 0, 32'h5100_0003, 2'b11, 2'b11);
      #1 rst_n_in = 1'b0;
      #1 check("rst_abort", pack_out(), pack_exp(0, 2'b00, 2'b00, 0, 0, 0, 32'h5100_0003));
      @(negedge clk_in); rst_n_in = 1'b1; drive(1, 1, 1, 32'h5200_0001, 2'b11, 2'b11); #2;
      check("rst_new_hdr", pack_out(), pack_exp(0, 2'b00, 2'b00, 0, 0, 0, 32'h5200_0001));
      @(negedge clk_in); drive(1, 1, 1, 32'h5200_0001, 2'b11, 2'b11); #2;
      check("rst_new_route", pack_out(), pack_exp(1, 2'b10, 2'b10, 1, 0, 0, 32'h5200_0001));
      @(negedge clk_in); drive(0, 0, 0, 32'h0, 2'b11, 2'b11); #2;
      check("rst_idle", pack_out(), pack_exp(0, 2'b00, 2'b00, 0, 0, 0, 32'h0));

      // Randomized packets; expectations derived per packet from the routing rules
      exp_drop = 0; exp_trunc = 0; abort = 1'b0;
      for (int p = 0; p < 300 && !abort; p++) begin
         dest = $urandom_range(0, 4);
         len  = $urandom_range(1, 7);
         en   = 2'($urandom);
         for (int k = 0; k < len; k++) beats[k] = $urandom;
         ok = (dest < NC) && en[dest];
         if (ok) begin
            for (int k = 0; k < len && k < MB; k++) begin
               w.ch = dest; w.d = beats[k]; w.l = (k == len - 1) || (k == MB - 1);
               expq.push_back(w);
            end
            if (len > MB) exp_trunc++;
         end else begin
            exp_drop++;
         end
         hdr = 1'b0;
         for (int k = 0; k < len && !abort; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(negedge clk_in);
               drive(0, 4'($urandom), 0, $urandom, hdr ? 2'($urandom) : en, 2'($urandom));
               #2 mon();
            end
            done = 1'b0; budget = 0;
            while (!done && !abort) begin
               @(negedge clk_in);
               // tdest/enables scramble after the header cycle; they must not matter
               drive(1, hdr ? 4'($urandom) : 4'(dest), (k == len - 1), beats[k],
                     hdr ? 2'($urandom) : en,
                     {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
               #2 mon();
               hdr  = 1'b1;
               done = tready;
               budget++;
               if (!done && budget > 40) begin
                  n_tests++; n_fail++; abort = 1'b1;
                  $display("FAIL rand_timeout: packet %0d beat %0d not accepted in 40 cycles", p, k);
               end
            end
         end
      end
      @(negedge clk_in); drive(0, 0, 0, 32'h0, 2'b11, 2'b11); #2 mon();
      @(negedge clk_in); #2 mon();
      check("rand_pending_writes", 96'(expq.size()), 96'd0);
      check("rand_drop_sat", 96'(drop_cnt), 96'((exp_drop > 7) ? 7 : exp_drop));
      check("rand_trunc_sat", 96'(trunc_cnt), 96'((exp_trunc > 7) ? 7 : exp_trunc));
      check("rand_idle", 96'({busy, tready, fifo_stb}), 96'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
